// File: rtl/dp_ir_reg.sv
// Debug-port instruction register: IR shift chain, update latch, registered
// data-register select decode and sticky EJTAG boot request.
module dp_ir_reg #(
  parameter int unsigned WIDTH      = 5,
  parameter logic [31:0] RST_INSTR  = 32'h0000_0001,
  parameter bit          UNK_BYPASS = 1'b0
) (
  input  logic             tck,
  input  logic             trst_n,
  input  logic             tlr,
  input  logic             capture_ir,
  input  logic             shift_ir,
  input  logic             update_ir,
  input  logic             tdi,
  output logic             tdo_ir,
  output logic [WIDTH-1:0] ir,
  output logic [3:0]       sel,
  output logic             ir_upd,
  output logic             ir_illegal,
  output logic             ejtag_boot
);

  localparam logic [WIDTH-1:0] CodeIdcode     = WIDTH'(8'h01);
  localparam logic [WIDTH-1:0] CodeSample     = WIDTH'(8'h02);
  localparam logic [WIDTH-1:0] CodeImpcode    = WIDTH'(8'h03);
  localparam logic [WIDTH-1:0] CodeAddress    = WIDTH'(8'h08);
  localparam logic [WIDTH-1:0] CodeData       = WIDTH'(8'h09);
  localparam logic [WIDTH-1:0] CodeControl    = WIDTH'(8'h0A);
  localparam logic [WIDTH-1:0] CodeEjtagBoot  = WIDTH'(8'h0C);
  localparam logic [WIDTH-1:0] CodeNormalBoot = WIDTH'(8'h0D);

  localparam logic [3:0] SelIdcode  = 4'd0;
  localparam logic [3:0] SelImpcode = 4'd1;
  localparam logic [3:0] SelAddress = 4'd2;
  localparam logic [3:0] SelData    = 4'd3;
  localparam logic [3:0] SelControl = 4'd4;
  localparam logic [3:0] SelBoot    = 4'd5;
  localparam logic [3:0] SelBypass  = 4'd6;
  localparam logic [3:0] SelSample  = 4'd7;
  localparam logic [3:0] SelAny     = 4'd8;

  // 1149.1 requires the two LSBs captured as 01; the rest are zero here.
  localparam logic [WIDTH-1:0] CapPattern = WIDTH'(1);
  localparam logic [WIDTH-1:0] RstCode    = RST_INSTR[WIDTH-1:0];

  // Returns {illegal, sel}.
  function automatic logic [4:0] decode(input logic [WIDTH-1:0] code);
    logic [3:0] s;
    logic       ill;
    ill = 1'b0;
    case (code)
      CodeIdcode:     s = SelIdcode;
      CodeImpcode:    s = SelImpcode;
      CodeAddress:    s = SelAddress;
      CodeData:       s = SelData;
      CodeControl:    s = SelControl;
      CodeEjtagBoot:  s = SelBoot;
      CodeNormalBoot: s = SelBypass;
      CodeSample:     s = SelSample;
      default: begin
        if (&code) begin
          s = SelBypass;
        end else begin
          ill = 1'b1;
          s   = UNK_BYPASS ? SelBypass : SelAny;
        end
      end
    endcase
    return {ill, s};
  endfunction

  localparam logic [4:0] RstDecode = decode(RstCode);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [3:0]       sel_q, sel_d;
  logic             illegal_q, illegal_d;
  logic             upd_q, upd_d;
  logic             boot_q, boot_d;

  // Priority: tlr > update > capture > shift; lower strobes are dropped.
  always_comb begin
    sr_d   = sr_q;
    ir_d   = ir_q;
    upd_d  = 1'b0;
    boot_d = boot_q;
    if (tlr) begin
      ir_d  = RstCode;
      sr_d  = CapPattern;
      upd_d = 1'b1;
    end else if (update_ir) begin
      ir_d  = sr_q;
      upd_d = 1'b1;
      if (sr_q == CodeEjtagBoot) begin
        boot_d = 1'b1;
      end else if (sr_q == CodeNormalBoot) begin
        boot_d = 1'b0;
      end
    end else if (capture_ir) begin
      sr_d = CapPattern;
    end else if (shift_ir) begin
      sr_d = {tdi, sr_q[WIDTH-1:1]};
    end
    // Decode the next instruction so sel lands in the same cycle as ir.
    {illegal_d, sel_d} = decode(ir_d);
  end

  always_ff @(posedge tck) begin
    if (!trst_n) begin
      sr_q      <= CapPattern;
      ir_q      <= RstCode;
      sel_q     <= RstDecode[3:0];
      illegal_q <= RstDecode[4];
      upd_q     <= 1'b0;
      boot_q    <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      ir_q      <= ir_d;
      sel_q     <= sel_d;
      illegal_q <= illegal_d;
      upd_q     <= upd_d;
      boot_q    <= boot_d;
    end
  end

  assign tdo_ir     = sr_q[0];
  assign ir         = ir_q;
  assign sel        = sel_q;
  assign ir_upd     = upd_q;
  assign ir_illegal = illegal_q;
  assign ejtag_boot = boot_q;

endmodule

// File: tb/tb_dp_ir_reg.sv
// Directed bench for dp_ir_reg: 5-bit (both unknown-code modes), 8-bit and
// 4-bit instances share strobes; each width gets its own aligned tdi.
module tb_dp_ir_reg;

  logic tck = 1'b0;
  logic trst_n, tlr, capture_ir, shift_ir, update_ir;
  logic tdi5, tdi8, tdi4;

  logic       tdo0, upd0, ill0, boot0;
  logic [4:0] ir0;
  logic [3:0] sel0;
  logic       tdo1, upd1, ill1, boot1;
  logic [4:0] ir1;
  logic [3:0] sel1;
  logic       tdo8, upd8, ill8, boot8;
  logic [7:0] ir8;
  logic [3:0] sel8;
  logic       tdo4, upd4, ill4, boot4;
  logic [3:0] ir4;
  logic [3:0] sel4;

  int checks = 0;
  int errors = 0;

  always #5 tck = ~tck;

  dp_ir_reg #(.WIDTH(5), .RST_INSTR(32'h01), .UNK_BYPASS(1'b0)) u_d0 (
    .tck(tck), .trst_n(trst_n), .tlr(tlr), .capture_ir(capture_ir), .shift_ir(shift_ir),
    .update_ir(update_ir), .tdi(tdi5), .tdo_ir(tdo0), .ir(ir0), .sel(sel0), .ir_upd(upd0),
    .ir_illegal(ill0), .ejtag_boot(boot0)
  );
  dp_ir_reg #(.WIDTH(5), .RST_INSTR(32'h01), .UNK_BYPASS(1'b1)) u_d1 (
    .tck(tck), .trst_n(trst_n), .tlr(tlr), .capture_ir(capture_ir), .shift_ir(shift_ir),
    .update_ir(update_ir), .tdi(tdi5), .tdo_ir(tdo1), .ir(ir1), .sel(sel1), .ir_upd(upd1),
    .ir_illegal(ill1), .ejtag_boot(boot1)
  );
  dp_ir_reg #(.WIDTH(8), .RST_INSTR(32'h01), .UNK_BYPASS(1'b0)) u_d8 (
    .tck(tck), .trst_n(trst_n), .tlr(tlr), .capture_ir(capture_ir), .shift_ir(shift_ir),
    .update_ir(update_ir), .tdi(tdi8), .tdo_ir(tdo8), .ir(ir8), .sel(sel8), .ir_upd(upd8),
    .ir_illegal(ill8), .ejtag_boot(boot8)
  );
  dp_ir_reg #(.WIDTH(4), .RST_INSTR(32'h01), .UNK_BYPASS(1'b0)) u_d4 (
    .tck(tck), .trst_n(trst_n), .tlr(tlr), .capture_ir(capture_ir), .shift_ir(shift_ir),
    .update_ir(update_ir), .tdi(tdi4), .tdo_ir(tdo4), .ir(ir4), .sel(sel4), .ir_upd(upd4),
    .ir_illegal(ill4), .ejtag_boot(boot4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge tck);
    #1;
  endtask

  // Capture, shift 8 bits (each width ends holding val truncated), update.
  task automatic load(input logic [7:0] val);
    capture_ir = 1'b1;
    cycle();
    capture_ir = 1'b0;
    shift_ir   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tdi8 = val[i];
      tdi5 = (i >= 3) ? val[i-3] : 1'b0;
      tdi4 = (i >= 4) ? val[i-4] : 1'b0;
      cycle();
    end
    shift_ir  = 1'b0;
    update_ir = 1'b1;
    cycle();
    update_ir = 1'b0;
  endtask

  typedef struct {
    logic [7:0] code;
    logic [3:0] s0;
    logic [3:0] s1;
    logic       ill;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [4:0] pat;
    tbl[0] = '{8'h01, 4'd0, 4'd0, 1'b0};
    tbl[1] = '{8'h03, 4'd1, 4'd1, 1'b0};
    tbl[2] = '{8'h08, 4'd2, 4'd2, 1'b0};
    tbl[3] = '{8'h09, 4'd3, 4'd3, 1'b0};
    tbl[4] = '{8'h0A, 4'd4, 4'd4, 1'b0};
    tbl[5] = '{8'h0C, 4'd5, 4'd5, 1'b0};
    tbl[6] = '{8'h0D, 4'd6, 4'd6, 1'b0};
    tbl[7] = '{8'h02, 4'd7, 4'd7, 1'b0};
    tbl[8] = '{8'h1F, 4'd6, 4'd6, 1'b0};
    tbl[9] = '{8'h10, 4'd8, 4'd6, 1'b1};

    trst_n = 1'b0; tlr = 1'b0; capture_ir = 1'b0; shift_ir = 1'b0; update_ir = 1'b0;
    tdi5 = 1'b0; tdi8 = 1'b0; tdi4 = 1'b0;

    // Reset
    cycle();
    cycle();
    chk("rst_ir", ir0, 5'h01);
    chk("rst_sel", sel0, 4'd0);
    chk("rst_tdo", tdo0, 1'b1);
    chk("rst_upd", upd0, 1'b0);
    chk("rst_ill", ill0, 1'b0);
    chk("rst_boot", boot0, 1'b0);
    trst_n = 1'b1;

    // Capture then shift 0x0A LSB-first; tdo shows captured 00001
    capture_ir = 1'b1;
    cycle();
    capture_ir = 1'b0;
    shift_ir   = 1'b1;
    pat        = 5'h0A;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("shift_tdo%0d", i), tdo0, (i == 0) ? 1'b1 : 1'b0);
      tdi5 = pat[i];
      cycle();
    end
    shift_ir = 1'b0;
    chk("pre_upd", upd0, 1'b0);
    update_ir = 1'b1;
    cycle();
    update_ir = 1'b0;
    chk("upd_ir", ir0, 5'h0A);
    chk("upd_sel", sel0, 4'd4);
    chk("upd_pulse", upd0, 1'b1);
    cycle();
    chk("upd_drop", upd0, 1'b0);
    chk("upd_hold_ir", ir0, 5'h0A);

    // Every code in both unknown-code modes
    for (int k = 0; k < 10; k++) begin
      load(tbl[k].code);
      chk($sformatf("code%0h_ir", tbl[k].code), ir0, tbl[k].code[4:0]);
      chk($sformatf("code%0h_sel0", tbl[k].code), sel0, tbl[k].s0);
      chk($sformatf("code%0h_sel1", tbl[k].code), sel1, tbl[k].s1);
      chk($sformatf("code%0h_ill0", tbl[k].code), ill0, tbl[k].ill);
      chk($sformatf("code%0h_ill1", tbl[k].code), ill1, tbl[k].ill);
    end

    // Sticky boot request
    chk("boot_start", boot0, 1'b0);
    load(8'h0C);
    chk("boot_set", boot0, 1'b1);
    tlr = 1'b1;
    cycle();
    tlr = 1'b0;
    chk("tlr_ir", ir0, 5'h01);
    chk("tlr_sel", sel0, 4'd0);
    chk("tlr_upd", upd0, 1'b1);
    chk("tlr_boot", boot0, 1'b1);
    load(8'h0D);
    chk("boot_clr", boot0, 1'b0);
    load(8'h0C);
    chk("boot_set2", boot0, 1'b1);
    trst_n = 1'b0;
    cycle();
    chk("trst_boot", boot0, 1'b0);
    chk("trst_ir", ir0, 5'h01);
    chk("trst_upd", upd0, 1'b0);
    trst_n = 1'b1;

    // Priority: update beats capture; tlr beats update
    capture_ir = 1'b1;
    cycle();
    capture_ir = 1'b0;
    shift_ir   = 1'b1;
    pat        = 5'h09;
    for (int i = 0; i < 5; i++) begin
      tdi5 = pat[i];
      cycle();
    end
    shift_ir   = 1'b0;
    update_ir  = 1'b1;
    capture_ir = 1'b1;
    cycle();
    capture_ir = 1'b0;
    chk("pri_uc_ir", ir0, 5'h09);
    chk("pri_uc_sel", sel0, 4'd3);
    chk("pri_uc_upd", upd0, 1'b1);
    cycle();
    chk("pri_sr_kept", ir0, 5'h09);
    chk("b2b_upd", upd0, 1'b1);
    tlr = 1'b1;
    cycle();
    tlr       = 1'b0;
    update_ir = 1'b0;
    chk("pri_tlr_ir", ir0, 5'h01);
    chk("pri_tlr_sel", sel0, 4'd0);
    cycle();
    chk("pri_idle_upd", upd0, 1'b0);

    // Width 8 and 4
    load(8'hFF);
    chk("w8_ones_ir", ir8, 8'hFF);
    chk("w8_ones_sel", sel8, 4'd6);
    chk("w4_ones_ir", ir4, 4'hF);
    chk("w4_ones_sel", sel4, 4'd6);
    chk("w4_ones_ill", ill4, 1'b0);
    load(8'h03);
    chk("w8_imp_ir", ir8, 8'h03);
    chk("w8_imp_sel", sel8, 4'd1);
    chk("w4_imp_ir", ir4, 4'h3);
    chk("w4_imp_sel", sel4, 4'd1);
    trst_n = 1'b0;
    cycle();
    trst_n   = 1'b1;
    shift_ir = 1'b1;
    tdi8 = 1'b0; tdi5 = 1'b0; tdi4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("w8_tdo%0d", i), tdo8, (i == 0) ? 1'b1 : 1'b0);
      if (i < 4) chk($sformatf("w4_tdo%0d", i), tdo4, (i == 0) ? 1'b1 : 1'b0);
      cycle();
    end
    shift_ir = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
